// File: rtl/sky130_fd_io__hvclamp_trig_ctl_if.sv
// sky130_fd_io__hvclamp_trig_ctl_if: detector/control inputs and clamp status outputs of the HV clamp trigger controller
//   ramp_det     async rail-ramp comparator output, active-high
//   clamp_dis    synchronous disable of automatic triggering
//   force_on     synchronous test override of ogc_en
//   cnt_clr      synchronous clear of event_cnt and timeout_flag
//   ogc_en       registered clamp gate enable
//   busy         high while clamping or cooling down
//   event_cnt    saturating count of automatic clamp events
//   timeout_flag sticky, set when a clamp hit its maximum duration
interface sky130_fd_io__hvclamp_trig_ctl_if #(parameter int CNT_W = 8);
    logic             ramp_det;
    logic             clamp_dis;
    logic             force_on;
    logic             cnt_clr;
    logic             ogc_en;
    logic             busy;
    logic [CNT_W-1:0] event_cnt;
    logic             timeout_flag;
    modport master (output ramp_det, clamp_dis, force_on, cnt_clr,
                    input  ogc_en, busy, event_cnt, timeout_flag);
    modport slave  (input  ramp_det, clamp_dis, force_on, cnt_clr,
                    output ogc_en, busy, event_cnt, timeout_flag);
endinterface

// File: rtl/sky130_fd_io__hvclamp_trig_ctl.sv
// sky130_fd_io__hvclamp_trig_ctl: debounced, retriggerable, time-capped HV ESD clamp trigger with cooldown lockout
//   clk   controller clock
//   reset asynchronous active-high reset
//   bus   slave side of sky130_fd_io__hvclamp_trig_ctl_if (detector/control in, gate enable/status out)
module sky130_fd_io__hvclamp_trig_ctl #(
    parameter int DEB_CYC  = 3,
    parameter int HOLD_CYC = 64,
    parameter int MAX_CYC  = 1024,
    parameter int COOL_CYC = 16,
    parameter int CNT_W    = 8
) (
    input logic clk,
    input logic reset,
    sky130_fd_io__hvclamp_trig_ctl_if.slave bus
);
    localparam int DW = $clog2(DEB_CYC + 1);
    localparam int HW = $clog2(HOLD_CYC + 1);
    localparam int XW = $clog2(MAX_CYC + 1);
    localparam int CW = $clog2(COOL_CYC + 1);
    typedef enum logic [1:0] {IDLE, CLAMP, COOLDOWN} state_t;
    state_t state, state_n;
    logic s1, s;
    logic [DW-1:0] deb, deb_n;
    logic [HW-1:0] hold, hold_n;
    logic [XW-1:0] ext, ext_n;
    logic [CW-1:0] cool, cool_n;
    logic [CNT_W-1:0] evt;
    logic fire, tmo, ogc, bsy, tflag;
    // The transition into CLAMP is taken on the edge that sees the DEB_CYC-th
    // consecutive high sample, so ogc_en (registered from next state) rises on
    // that same edge.
    always_comb begin
        state_n = state;
        deb_n = '0;
        hold_n = hold;
        ext_n = ext;
        cool_n = cool;
        fire = 1'b0;
        tmo = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.clamp_dis && s) begin
                    if (deb == DW'(DEB_CYC - 1)) begin
                        fire = 1'b1;
                        state_n = CLAMP;
                        hold_n = HW'(HOLD_CYC);
                        ext_n = XW'(1);
                    end else
                        deb_n = deb + DW'(1);
                end
            end
            CLAMP: begin
                tmo = ext == XW'(MAX_CYC);
                hold_n = s ? HW'(HOLD_CYC) : hold - HW'(1);
                ext_n = tmo ? ext : ext + XW'(1);
                if (bus.clamp_dis || (!s && hold == HW'(1)) || tmo) begin
                    state_n = COOLDOWN;
                    cool_n = '0;
                end
            end
            default: begin
                cool_n = cool + CW'(1);
                if (cool == CW'(COOL_CYC - 1))
                    state_n = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s <= 1'b0;
            state <= IDLE;
            deb <= '0;
            hold <= '0;
            ext <= '0;
            cool <= '0;
            evt <= '0;
            ogc <= 1'b0;
            bsy <= 1'b0;
            tflag <= 1'b0;
        end else begin
            s1 <= bus.ramp_det;
            s <= s1;
            state <= state_n;
            deb <= deb_n;
            hold <= hold_n;
            ext <= ext_n;
            cool <= cool_n;
            ogc <= (state_n == CLAMP) || bus.force_on;
            bsy <= state_n != IDLE;
            // a clear coinciding with a new event still records that event
            evt <= fire ? (bus.cnt_clr ? CNT_W'(1) : evt + CNT_W'(evt != '1))
                        : (bus.cnt_clr ? '0 : evt);
            // a timeout coinciding with a clear still sets the flag
            tflag <= tmo || (tflag && !bus.cnt_clr);
        end
    end
    assign bus.ogc_en = ogc;
    assign bus.busy = bsy;
    assign bus.event_cnt = evt;
    assign bus.timeout_flag = tflag;
endmodule
